// File: rtl/sram_bist_ctrl.sv
// March C- BIST engine for one RM_IHPSG13_1P macro; SRAM_BIST_ERRCNT_EN keeps running past mismatches and counts them.
// Fault-free run holds busy for 10N+1 cycles (one op per cycle plus drain); start is ignored while busy.
module sram_bist_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
`ifdef SRAM_BIST_ERRCNT_EN
  output logic [15:0]           err_count,
`endif
  output logic                  bist_en,
  output logic                  bist_men,
  output logic                  bist_wen,
  output logic                  bist_ren,
  output logic [ADDR_WIDTH-1:0] bist_addr,
  output logic [DATA_WIDTH-1:0] bist_din,
  output logic [DATA_WIDTH-1:0] bist_bm,
  input  logic [DATA_WIDTH-1:0] bist_dout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
`ifdef SRAM_BIST_ERRCNT_EN
  localparam bit STOP_ON_FAIL = 1'b0;
`else
  localparam bit STOP_ON_FAIL = 1'b1;
`endif

  state_t                  state, state_nxt;
  logic [2:0]              elem;
  logic                    op;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    cmp_vld;
  logic                    cmp_exp;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic                    desc, is_wr, wr_val, rd_val, last_op, last_addr;
  logic                    mismatch, accept, issue;

  // Element decode: M0 w0 | M1 r0,w1 | M2 r1,w0 | M3 r0,w1 | M4 r1,w0 | M5 r0
  always_comb begin
    desc      = (elem >= 3'd3);
    last_op   = (elem == 3'd0 || elem == 3'd5) ? 1'b1 : op;
    is_wr     = (elem == 3'd0) ? 1'b1 : ((elem == 3'd5) ? 1'b0 : op);
    wr_val    = (elem == 3'd1 || elem == 3'd3);
    rd_val    = (elem == 3'd2 || elem == 3'd4);
    last_addr = desc ? (addr == '0) : (addr == ADDR_MAX);
    mismatch  = cmp_vld && (state == RUN || state == DRAIN) &&
                (bist_dout != {DATA_WIDTH{cmp_exp}});
    accept    = start && (state == IDLE || state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN: begin
        if (STOP_ON_FAIL && mismatch)                  state_nxt = DONE;
        else if (elem == 3'd5 && last_op && last_addr) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue     = (state == RUN);
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    bist_en   = busy;
    bist_men  = issue;
    bist_wen  = issue && is_wr;
    bist_ren  = issue && !is_wr;
    bist_addr = issue ? addr : '0;
    bist_din  = (issue && is_wr && wr_val) ? {DATA_WIDTH{1'b1}} : '0;
    bist_bm   = (issue && is_wr) ? {DATA_WIDTH{1'b1}} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem      <= '0;
      op        <= 1'b0;
      addr      <= '0;
      cmp_vld   <= 1'b0;
      cmp_exp   <= 1'b0;
      cmp_addr  <= '0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef SRAM_BIST_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      cmp_vld  <= issue && !is_wr;
      cmp_exp  <= rd_val;
      cmp_addr <= addr;
      if (accept) begin
        elem      <= '0;
        op        <= 1'b0;
        addr      <= '0;
        cmp_vld   <= 1'b0;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
`ifdef SRAM_BIST_ERRCNT_EN
        err_count <= '0;
`endif
      end else begin
        if (issue) begin
          if (!last_op) begin
            op <= 1'b1;
          end else begin
            op <= 1'b0;
            if (last_addr) begin
              elem <= elem + 3'd1;
              addr <= (elem >= 3'd2) ? ADDR_MAX : '0;
            end else begin
              addr <= desc ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
            end
          end
        end
`ifdef SRAM_BIST_ERRCNT_EN
        // Only the first mismatch is recorded; the counter keeps going until saturation
        if (mismatch) begin
          if (err_count == '0) begin
            fail_addr <= cmp_addr;
            fail_data <= bist_dout;
          end
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
        if (state == DRAIN && !mismatch && err_count == '0) pass <= 1'b1;
`else
        if (mismatch) begin
          fail_addr <= cmp_addr;
          fail_data <= bist_dout;
        end
        if (state == DRAIN && !mismatch) pass <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: behavioural 8-word SRAM with selectable fault, table-driven runs plus abort sequence.
module tb_sram_bist_ctrl;
  localparam int AW   = 3;
  localparam int DW   = 32;
  localparam int N    = 8;
  localparam int NOPS = 10 * N;
  localparam int LIMIT = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
`ifdef SRAM_BIST_ERRCNT_EN
  logic [15:0]   err_count;
`endif
  logic          bist_en, bist_men, bist_wen, bist_ren;
  logic [AW-1:0] bist_addr;
  logic [DW-1:0] bist_din, bist_bm;
  logic [DW-1:0] bist_dout = '0;

  sram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
`ifdef SRAM_BIST_ERRCNT_EN
    .err_count (err_count),
`endif
    .bist_en   (bist_en),
    .bist_men  (bist_men),
    .bist_wen  (bist_wen),
    .bist_ren  (bist_ren),
    .bist_addr (bist_addr),
    .bist_din  (bist_din),
    .bist_bm   (bist_bm),
    .bist_dout (bist_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM. fault_mode 1: bit 5 of word 6 stuck at 0; 2: writing ones to word 2 sets word 3 to ones.
  int            fault_mode = 0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wdat, rdat;

  always @(posedge clk) begin
    if (bist_men && bist_wen) begin
      wdat = (bist_din & bist_bm) | (mem[bist_addr] & ~bist_bm);
      mem[bist_addr] <= wdat;
      if (fault_mode == 2 && bist_addr == 3'd2 && wdat == '1) mem[3] <= '1;
    end
    if (bist_men && bist_ren) begin
      rdat = mem[bist_addr];
      if (fault_mode == 1 && bist_addr == 3'd6) rdat[5] = 1'b0;
      bist_dout <= rdat;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected March C- op stream, built from the element table
  logic          exp_wen  [NOPS];
  logic [AW-1:0] exp_addr [NOPS];
  logic [DW-1:0] exp_din  [NOPS];

  task automatic build_ops();
    int nops [6];
    int kind [6][2];
    int idx;
    logic [AW-1:0] a;
    nops = '{1, 2, 2, 2, 2, 1};
    // 0=w0 1=w1 2=r0 3=r1
    kind = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
    idx = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = (e >= 3) ? AW'(N - 1 - i) : AW'(i);
        for (int o = 0; o < nops[e]; o++) begin
          exp_wen[idx]  = (kind[e][o] < 2);
          exp_addr[idx] = a;
          exp_din[idx]  = (kind[e][o] == 1) ? '1 : '0;
          idx++;
        end
      end
  endtask

  // Pulses start, then counts busy cycles while checking each issued op against the expected stream.
  task automatic run(input int fm, input int again_at, input int abort_at,
                     output int cyc, output int op_err, output int port_err);
    fault_mode = fm;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0; op_err = 0; port_err = 0;
    while (busy === 1'b1 && cyc < LIMIT) begin
      cyc++;
      start = (cyc == again_at);
      if (bist_en !== 1'b1) port_err++;
      if (bist_men && bist_wen && (bist_bm !== '1)) port_err++;
      if (bist_men && (bist_wen === bist_ren)) port_err++;
      if (cyc <= NOPS) begin
        if (bist_men !== 1'b1 || bist_wen !== exp_wen[cyc-1] || bist_ren !== !exp_wen[cyc-1] ||
            bist_addr !== exp_addr[cyc-1] || bist_din !== exp_din[cyc-1]) op_err++;
      end else if (bist_men !== 1'b0) begin
        op_err++;
      end
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctl", {busy, done, pass, bist_en, bist_men, bist_wen, bist_ren}, 0);
        check("abort_addr", {bist_addr, fail_addr}, 0);
        check("abort_din_bm", {bist_din, bist_bm}, 0);
        check("abort_fdata", fail_data, 0);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int            fm;
    int            cyc;
    logic          pas;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    int            ec;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cyc, op_err, port_err;

    build_ops();
    vecs[0] = '{0, 81, 1'b1, 3'd0, 32'h0000_0000, 0};
`ifdef SRAM_BIST_ERRCNT_EN
    vecs[1] = '{1, 81, 1'b0, 3'd6, 32'hFFFF_FFDF, 2};
    vecs[2] = '{2, 81, 1'b0, 3'd3, 32'hFFFF_FFFF, 1};
`else
    vecs[1] = '{1, 38, 1'b0, 3'd6, 32'hFFFF_FFDF, 0};
    vecs[2] = '{2, 16, 1'b0, 3'd3, 32'hFFFF_FFFF, 0};
`endif
    vecs[3] = '{0, 81, 1'b1, 3'd0, 32'h0000_0000, 0};

    #1;
    check("rst_ctl", {busy, done, pass, bist_en, bist_men, bist_wen, bist_ren}, 0);
    check("rst_addr", {bist_addr, fail_addr}, 0);
    check("rst_din_bm", {bist_din, bist_bm}, 0);
    check("rst_fdata", fail_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ops", {bist_en, bist_men, bist_wen, bist_ren, busy, done}, 0);

    for (int v = 0; v < 4; v++) begin
      run(vecs[v].fm, 0, 0, cyc, op_err, port_err);
      check($sformatf("v%0d_busy_cycles", v), cyc, vecs[v].cyc);
      check($sformatf("v%0d_op_order", v), op_err, 0);
      check($sformatf("v%0d_port_rules", v), port_err, 0);
      check($sformatf("v%0d_done", v), done, 1);
      check($sformatf("v%0d_pass", v), pass, vecs[v].pas);
      check($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].fa);
      check($sformatf("v%0d_fail_data", v), fail_data, vecs[v].fd);
      check($sformatf("v%0d_done_quiet", v), {bist_en, bist_men, bist_wen, bist_ren}, 0);
`ifdef SRAM_BIST_ERRCNT_EN
      check($sformatf("v%0d_err_count", v), err_count, vecs[v].ec);
`endif
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_done_held", v), {done, pass, fail_addr}, {1'b1, vecs[v].pas, vecs[v].fa});
    end

    // Second start at cycle 20 must be ignored; reset at cycle 40 aborts
    run(0, 20, 40, cyc, op_err, port_err);
    check("abort_cycle", cyc, 40);
    check("abort_op_order", op_err, 0);
    check("abort_port_rules", port_err, 0);
    repeat (2) @(negedge clk);
    check("abort_held_ctl", {busy, done, pass, bist_men}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 0, 0, cyc, op_err, port_err);
    check("rerun_busy_cycles", cyc, 81);
    check("rerun_op_order", op_err, 0);
    check("rerun_done_pass", {done, pass}, 2'b11);
    check("rerun_fail_fields", {fail_addr, fail_data}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Built-in self-test engine that drives the A_BIST_* port of one RM_IHPSG13_1P SRAM macro and checks read data on A_DOUT.
- Runs a March C- sequence over the whole array, then reports pass/fail plus the first failing address and data.
- Instantiated next to each SRAM in chip_core. Its outputs replace the tied-off BIST port connections.

Parameters:
- ADDR_WIDTH, 10, SRAM address width; N = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, SRAM data width; also the width of the byte-mask-per-bit vector.

Ports:
- clk  input  1  clock; also drives bist_clk to the macro.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; starts a test when idle.
- busy  output  1  test in progress.
- done  output  1  sticky; test finished. Cleared by the next accepted start.
- pass  output  1  valid while done=1; 1 means no mismatch was seen.
- fail_addr  output  ADDR_WIDTH  address of the first mismatching read.
- fail_data  output  DATA_WIDTH  data read at fail_addr.
- bist_en  output  1  to A_BIST_EN; selects the BIST port; high while busy.
- bist_men  output  1  to A_BIST_MEN; memory enable for the issued op.
- bist_wen  output  1  to A_BIST_WEN; active-high write.
- bist_ren  output  1  to A_BIST_REN; active-high read.
- bist_addr  output  ADDR_WIDTH  to A_BIST_ADDR.
- bist_din  output  DATA_WIDTH  to A_BIST_DIN.
- bist_bm  output  DATA_WIDTH  to A_BIST_BM; all ones on every write.
- bist_dout  input  DATA_WIDTH  from A_DOUT; valid one cycle after a read is issued.

Behaviour:
- Reset values (rst_n=0, async): all outputs 0, state IDLE.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: outputs inactive. When start=1, go to RUN on the next edge: busy=1, done=0, pass=0, element=0, op=0, addr=0 (ascending) or N-1 (descending).
- RUN issues one SRAM op per cycle. bist_men=1 and exactly one of bist_wen/bist_ren is 1. bist_din = all ones when writing 1, all zeros when writing 0.
- March elements and their op sequence per address:
  - M0 ascending: w0
  - M1 ascending: r0, w1
  - M2 ascending: r1, w0
  - M3 descending: r0, w1
  - M4 descending: r1, w0
  - M5 descending: r0
- Move to the next address after the last op of an element. Move to the next element after the last address. After the last M5 read, go to DRAIN.
- Compare pipeline: each read registers its expected value and address, with a valid flag. In the following cycle, bist_dout is compared against the expected value.
- Mismatch: capture fail_addr/fail_data from the pipeline register. Go straight to DONE with pass=0. Any op issued in the detection cycle is abandoned; a write issued then is harmless.
- DRAIN: one cycle with no op issued. The last compare happens here. If no mismatch, go to DONE with pass=1.
- DONE: busy=0, done=1, bist_en=0. Results are held. A new start restarts the test from RUN.
- Latency: with no fault, busy is high for exactly 10N+1 cycles (10N ops + drain). done rises on the edge after the drain cycle.
- start while busy: ignored.
- Address counter: exact ADDR_WIDTH wrap bounds. Terminal count is N-1 ascending and 0 descending; no overflow.
- Reset mid-test: aborts immediately, all outputs return to reset values, and SRAM contents are undefined.
- fail_addr/fail_data: 0 until a fault is captured; they then hold until the next start.

Optional Feature:
- Macro SRAM_BIST_ERRCNT_EN.
- Defined:
  - The test does not stop on a mismatch; it runs all 10N ops.
  - fail_addr/fail_data capture only the first mismatch.
  - Extra output err_count (16 bits) counts mismatching reads, saturating at 0xFFFF and cleared on start.
  - pass=1 only if err_count=0 at DONE.
- Not defined: stop on first fail as described above; err_count port absent.

Test Plan:
- Fault-free behavioural SRAM, ADDR_WIDTH=3: pulse start → busy high exactly 81 cycles; done=1, pass=1; 80 ops in March C- order; fail_addr=0, fail_data=0.
- Stuck-at-0 on bit 5 of word 6, ADDR_WIDTH=3: start → first mismatch on M2 r1 at addr 6; pass=0, fail_addr=6, fail_data=0xFFFFFFDF; busy drops within 2 cycles of that read.
- Coupling fault (write 1 to word 2 flips word 3 to 1), ADDR_WIDTH=3: start → fail at M1 r0 of addr 3; fail_data=0xFFFFFFFF.
- start pulsed again at cycle 20 of a run, then rst_n low at cycle 40 → second start ignored; all outputs 0 asynchronously; a new start afterwards completes normally with pass=1.
- Check every write cycle → bist_bm=all ones, bist_en=1; in IDLE/DONE bist_men=bist_wen=bist_ren=0.
- With SRAM_BIST_ERRCNT_EN, stuck-at-0 at word 6 bit 5 → run completes in 81 busy cycles; err_count=2 (M2 r1 and M4 r1 mismatch); pass=0, fail_addr=6.
